// File: rtl/norm_pkg.sv
// Shared types, widths and helpers for the psum normalization stage.
// Holds lane/row-sum widths, the row typedefs and per-lane math helpers.
package norm_pkg;

  localparam int BW_PSUM    = 20;
  localparam int COL        = 8;
  localparam int SUM_W      = BW_PSUM + 4;
  localparam int SUM_SHIFT  = 7;
  localparam int FIFO_DEPTH = 8;

  typedef logic [COL*BW_PSUM-1:0] psum_row_t;
  typedef logic [SUM_W-1:0]       row_sum_t;
  typedef logic [BW_PSUM-1:0]     lane_t;

  // One extra bit so the most negative lane keeps its full magnitude.
  function automatic logic [BW_PSUM:0] abs_mag(input lane_t x);
    logic [BW_PSUM:0] e;
    e = {x[BW_PSUM-1], x};
    return x[BW_PSUM-1] ? (~e + 1'b1) : e;
  endfunction

  // Signed lane over a non-negative divisor; zero divisor yields zero.
  function automatic lane_t lane_div(input lane_t x, input lane_t d);
    logic signed [BW_PSUM:0] n;
    logic signed [BW_PSUM:0] dv;
    logic signed [BW_PSUM:0] q;
    n  = {x[BW_PSUM-1], x};
    dv = {1'b0, d};
    if (d == '0) q = '0;
    else         q = n / dv;
    return q[BW_PSUM-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock valid-only queue; a push to a full queue is dropped.
// Ports: clk, reset, push_i, pop_i, din_i -> dout_o (head), full_o, empty_o.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr;
  logic             rd;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign rd      = pop_i && !empty_o;
  // A simultaneous pop frees the slot, so a full queue still accepts.
  assign wr      = push_i && (!full_o || rd);
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + AW'(1);
      if (rd) rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/norm_sfp.sv
// Psum normalization: row |psum| sums queued/exported, rows divided by summed norms.
// Ports: acc/div/psum_in, peer sum_in(_valid) -> sum_out(_valid), norm_out, norm_valid, ovf_err, udf_err.
module norm_sfp
  import norm_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      acc,
  input  logic      div,
  input  psum_row_t psum_in,
  input  row_sum_t  sum_in,
  input  logic      sum_in_valid,
  output row_sum_t  sum_out,
  output logic      sum_out_valid,
  output psum_row_t norm_out,
  output logic      norm_valid,
  output logic      ovf_err,
  output logic      udf_err
);

  row_sum_t  row_sum_d;
  row_sum_t  own_head;
  row_sum_t  peer_head;
  logic      own_full, own_empty;
  logic      peer_full, peer_empty;
  logic      pop;
  lane_t     denom;
  psum_row_t norm_d;

  row_sum_t  sum_q;
  logic      sum_vld_q;
  psum_row_t norm_q;
  logic      norm_vld_q;
  logic      ovf_q;
  logic      udf_q;

  always_comb begin
    row_sum_d = '0;
    for (int i = 0; i < COL; i++)
      row_sum_d = row_sum_d
                + SUM_W'(abs_mag(psum_in[i*BW_PSUM +: BW_PSUM]));
  end

  assign pop = div && !own_empty && !peer_empty;

  sync_fifo #(.WIDTH(SUM_W), .DEPTH(DEPTH)) u_own (
    .clk    (clk),
    .reset  (reset),
    .push_i (acc),
    .pop_i  (pop),
    .din_i  (row_sum_d),
    .dout_o (own_head),
    .full_o (own_full),
    .empty_o(own_empty)
  );

  sync_fifo #(.WIDTH(SUM_W), .DEPTH(DEPTH)) u_peer (
    .clk    (clk),
    .reset  (reset),
    .push_i (sum_in_valid),
    .pop_i  (pop),
    .din_i  (sum_in),
    .dout_o (peer_head),
    .full_o (peer_full),
    .empty_o(peer_empty)
  );

  assign denom = BW_PSUM'(own_head[SUM_W-1:SUM_SHIFT])
               + BW_PSUM'(peer_head[SUM_W-1:SUM_SHIFT]);

  always_comb begin
    norm_d = '0;
    for (int i = 0; i < COL; i++)
      norm_d[i*BW_PSUM +: BW_PSUM] =
        lane_div(psum_in[i*BW_PSUM +: BW_PSUM], denom);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      norm_q     <= '0;
      norm_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      sum_vld_q  <= acc;
      norm_vld_q <= pop;
      if (acc) sum_q  <= row_sum_d;
      if (pop) norm_q <= norm_d;
      if ((acc && own_full && !pop) ||
          (sum_in_valid && peer_full && !pop))
        ovf_q <= 1'b1;
      if (div && !pop) udf_q <= 1'b1;
    end
  end

  assign sum_out       = sum_q;
  assign sum_out_valid = sum_vld_q;
  assign norm_out      = norm_q;
  assign norm_valid    = norm_vld_q;
  assign ovf_err       = ovf_q;
  assign udf_err       = udf_q;

endmodule
